// File: rtl/rtype_pkg.sv
// +--------------------------------------------------------------------+
// | rtype_pkg                                                          |
// | Op codes, funct constants, queue entry type and R-type encoder.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package rtype_pkg;

  localparam logic [2:0] c_op_add = 3'd0;
  localparam logic [2:0] c_op_sub = 3'd1;
  localparam logic [2:0] c_op_and = 3'd2;
  localparam logic [2:0] c_op_or  = 3'd3;
  localparam logic [2:0] c_op_slt = 3'd4;

  localparam logic [5:0] c_funct_add = 6'h20;
  localparam logic [5:0] c_funct_sub = 6'h22;
  localparam logic [5:0] c_funct_and = 6'h24;
  localparam logic [5:0] c_funct_or  = 6'h25;
  localparam logic [5:0] c_funct_slt = 6'h2A;

  localparam logic [31:0] c_nop_word = 32'h0000_0000;
  localparam int          c_entry_w  = 18;

  typedef struct packed {
    logic [2:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } entry_t;

  typedef struct packed {
    logic [31:0] word;
    logic        illegal;
  } enc_t;

  // Illegal ops encode to the NOP word so the datapath never sees garbage.
  function automatic enc_t encode_rtype(input logic [2:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    enc_t       r;
    logic [5:0] funct;
    funct     = 6'h00;
    r.illegal = 1'b0;
    case (op)
      c_op_add: funct = c_funct_add;
      c_op_sub: funct = c_funct_sub;
      c_op_and: funct = c_funct_and;
      c_op_or:  funct = c_funct_or;
      c_op_slt: funct = c_funct_slt;
      default:  r.illegal = 1'b1;
    endcase
    r.word = r.illegal ? c_nop_word : {6'b000000, rs, rt, rd, 5'b00000, funct};
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rtype_fifo.sv
// +--------------------------------------------------------------------+
// | rtype_fifo                                                         |
// | DEPTH x WIDTH queue of decoded fields, async active-low reset.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module rtype_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int           c_aw  = $clog2(DEPTH);
  localparam logic [c_aw:0] c_one = 1;

  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw:0]    r_wptr;
  logic [c_aw:0]    r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_wptr == r_rptr);
  assign full      = (r_wptr[c_aw] != r_rptr[c_aw]) &&
                     (r_wptr[c_aw-1:0] == r_rptr[c_aw-1:0]);
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;
  assign rdata     = r_mem[r_rptr[c_aw-1:0]];

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + c_one;
      if (w_do_pop)  r_rptr <= r_rptr + c_one;
    end
  end

  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wptr[c_aw-1:0]] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/rtype_issue.sv
// +--------------------------------------------------------------------+
// | rtype_issue                                                        |
// | Queues R-type fields, encodes and issues one word per clock with   |
// | RAW-hazard bubbles. Define RTYPE_FWD_EN to drop hazard detection.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module rtype_issue
  import rtype_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int WB_LAT = 1
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        enable,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  output logic [31:0] instr,
  output logic        issue,
  output logic        empty,
  output logic        full,
  output logic [15:0] stall_cnt,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  entry_t      w_in;
  entry_t      w_head;
  enc_t        w_enc;
  logic        w_pop;
  logic        w_hazard;
  logic [31:0] r_instr;
  logic        r_issue;
  logic        r_err;

  assign w_in = {in_op, in_rs, in_rt, in_rd};

  rtype_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (c_entry_w)
  ) u_fifo (
    .clock (clock),
    .rst   (rst),
    .push  (in_valid),
    .wdata (w_in),
    .pop   (w_pop),
    .rdata (w_head),
    .full  (full),
    .empty (empty)
  );

  assign in_ready = ~full;
  assign w_enc    = encode_rtype(w_head.op, w_head.rs, w_head.rt, w_head.rd);

`ifdef RTYPE_FWD_EN
  assign w_hazard  = 1'b0;
  assign stall_cnt = 16'h0000;
`else
  logic [4:0]  r_sb [WB_LAT];
  logic [4:0]  w_sb_in;
  logic [15:0] r_stall_cnt;

  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < WB_LAT; i++) begin
      if ((r_sb[i] != 5'd0) && ((r_sb[i] == w_head.rs) || (r_sb[i] == w_head.rt)))
        w_hazard = 1'b1;
    end
  end

  // Only real issued instructions occupy the scoreboard; bubbles and NOPs age it with rd=0.
  assign w_sb_in = (w_pop && !w_enc.illegal) ? w_head.rd : 5'd0;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < WB_LAT; i++) r_sb[i] <= 5'd0;
      r_stall_cnt <= 16'h0000;
    end else begin
      r_sb[0] <= w_sb_in;
      for (int i = 1; i < WB_LAT; i++) r_sb[i] <= r_sb[i-1];
      if ((w_state_nxt == S_STALL) && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

  // Every state makes the same dispatch decision on each edge, so a word pushed into an
  // empty queue issues on the very edge that moves IDLE to RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    if (!enable || empty) begin
      w_state_nxt = S_IDLE;
    end else if (w_hazard) begin
      w_state_nxt = S_STALL;
    end else begin
      w_state_nxt = S_RUN;
      w_pop       = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_instr <= c_nop_word;
      r_issue <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_instr <= w_pop ? w_enc.word : c_nop_word;
      r_issue <= w_pop;
      if (w_pop && w_enc.illegal) r_err <= 1'b1;
    end
  end

  assign instr = r_instr;
  assign issue = r_issue;
  assign err   = r_err;

endmodule

`default_nettype wire
